// File: rtl/if_stage.sv
`default_nettype none
// if_stage: MIPS fetch stage -- PC register, next-PC select and IF/ID pipeline register.
// Define IF_ADDR_CHECK_EN to flag misaligned or out-of-IM fetch addresses into D_exc.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] F_PC,
  input  logic [31:0] F_Instr,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic        D_exc
);

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [31:0] npc;
  logic        fetch_exc;

`ifdef IF_ADDR_CHECK_EN
  // 33-bit limit so an IM ending exactly at 4 GiB does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  assign fetch_exc = (pc_q[1:0] != 2'b00) ||
                     (pc_q < IM_BASE) ||
                     ({1'b0, pc_q} >= IM_END);
`else
  logic unused_cfg;
  assign unused_cfg = ^{IM_BASE, IM_WORDS};
  assign fetch_exc  = 1'b0;
`endif

  always_comb begin
    npc = pc_q + 32'd4;
    unique case (npc_sel)
      NPC_SEQ: npc = pc_q + 32'd4;
      NPC_BR:  npc = br_target;
      NPC_J:   npc = {dpc_q[31:28], j_index, 2'b00};
      NPC_JR:  npc = jr_target;
      default: npc = pc_q + 32'd4;
    endcase
  end

  // Stall freezes every register; a redirect seen during stall is simply not taken.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    valid_d = valid_q;
    exc_d   = exc_q;
    if (!stall) begin
      pc_d    = npc;
      instr_d = fetch_exc ? 32'h0 : F_Instr;
      dpc_d   = pc_q;
      valid_d = 1'b1;
      exc_d   = fetch_exc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      dpc_q   <= PC_RESET;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
    end
  end

  assign F_PC    = pc_q;
  assign D_Instr = instr_q;
  assign D_PC    = dpc_q;
  assign D_valid = valid_q;
  assign D_exc   = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// tb_if_stage: directed vector table, reset corner cases and a randomized run
// against a behavioural fetch-stage model.
module tb_if_stage;

`ifdef IF_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic        D_valid;
  logic        D_exc;

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .br_target(br_target), .j_index(j_index), .jr_target(jr_target),
    .F_PC(F_PC), .F_Instr(F_Instr), .D_Instr(D_Instr), .D_PC(D_PC),
    .D_valid(D_valid), .D_exc(D_exc)
  );

  always #5 clk = ~clk;

  // Instruction memory: the word at byte address 0x3000+4*i holds the value i.
  function automatic logic [31:0] im_word(input logic [31:0] pc);
    return (pc - 32'h0000_3000) >> 2;
  endfunction
  assign F_Instr = im_word(F_PC);

  function automatic bit exc_of(input logic [31:0] pc);
    if (!CHK) return 1'b0;
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc >= 32'h7000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] fpc, input logic [31:0] dpc,
                         input logic [31:0] di, input logic v, input logic ex);
    chk({tag, ".F_PC"}, F_PC, fpc);
    chk({tag, ".D_PC"}, D_PC, dpc);
    chk({tag, ".D_Instr"}, D_Instr, di);
    chk({tag, ".D_valid"}, {31'b0, D_valid}, {31'b0, v});
    chk({tag, ".D_exc"}, {31'b0, D_exc}, {31'b0, ex});
  endtask

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] br;
    logic [25:0] jidx;
    logic [31:0] jr;
    logic [31:0] e_fpc;
    logic [31:0] e_dpc;
    logic [31:0] e_di;
    logic        e_exc;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic [31:0] br,
                              input logic [25:0] jidx, input logic [31:0] jr,
                              input logic [31:0] fpc, input logic [31:0] dpc,
                              input logic [31:0] di, input logic ex);
    vec_t v;
    v.stall = st; v.sel = sel; v.br = br; v.jidx = jidx; v.jr = jr;
    v.e_fpc = fpc; v.e_dpc = dpc; v.e_exc = ex;
    v.e_di  = ex ? 32'h0 : di;
    return v;
  endfunction

  // behavioural model state
  logic [31:0] m_fpc, m_dpc, m_di, n_fpc;
  logic        m_v, m_exc;

  initial begin
    tbl[0]  = mk(0, 2'd0, 0, 0, 0,             32'h3004, 32'h3000, 32'h0, 0);
    tbl[1]  = mk(0, 2'd0, 0, 0, 0,             32'h3008, 32'h3004, 32'h1, 0);
    tbl[2]  = mk(0, 2'd0, 0, 0, 0,             32'h300C, 32'h3008, 32'h2, 0);
    tbl[3]  = mk(0, 2'd1, 32'h3040, 0, 0,      32'h3040, 32'h300C, 32'h3, 0);
    tbl[4]  = mk(0, 2'd0, 0, 0, 0,             32'h3044, 32'h3040, 32'h10, 0);
    tbl[5]  = mk(0, 2'd3, 0, 0, 32'h3100,      32'h3100, 32'h3044, 32'h11, 0);
    tbl[6]  = mk(0, 2'd0, 0, 0, 0,             32'h3104, 32'h3100, 32'h40, 0);
    tbl[7]  = mk(0, 2'd2, 0, 26'h0000C80, 0,   32'h3200, 32'h3104, 32'h41, 0);
    tbl[8]  = mk(0, 2'd0, 0, 0, 0,             32'h3204, 32'h3200, 32'h80, 0);
    tbl[9]  = mk(1, 2'd0, 0, 0, 0,             32'h3204, 32'h3200, 32'h80, 0);
    tbl[10] = mk(1, 2'd3, 0, 0, 32'h3300,      32'h3204, 32'h3200, 32'h80, 0);
    tbl[11] = mk(0, 2'd3, 0, 0, 32'h3300,      32'h3300, 32'h3204, 32'h81, 0);
    tbl[12] = mk(0, 2'd0, 0, 0, 0,             32'h3304, 32'h3300, 32'hC0, 0);
    tbl[13] = mk(0, 2'd3, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3304, 32'hC1, 0);
    tbl[14] = mk(0, 2'd0, 0, 0, 0,             32'h0, 32'hFFFF_FFFC, 32'h3FFF_F3FF, CHK);
    tbl[15] = mk(0, 2'd3, 0, 0, 32'h3002,      32'h3002, 32'h0, 32'h3FFF_F400, CHK);
    tbl[16] = mk(0, 2'd3, 0, 0, 32'h7000,      32'h7000, 32'h3002, 32'h0, CHK);
    tbl[17] = mk(0, 2'd3, 0, 0, 32'h3000,      32'h3000, 32'h7000, 32'h1000, CHK);
    tbl[18] = mk(0, 2'd0, 0, 0, 0,             32'h3004, 32'h3000, 32'h0, 0);

    reset = 1'b0; stall = 1'b0; npc_sel = 2'd0;
    br_target = '0; j_index = '0; jr_target = '0;
    #12;
    chk_all("reset", 32'h3000, 32'h3000, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NV; i++) begin
      stall = tbl[i].stall; npc_sel = tbl[i].sel; br_target = tbl[i].br;
      j_index = tbl[i].jidx; jr_target = tbl[i].jr;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_fpc, tbl[i].e_dpc, tbl[i].e_di, 1'b1, tbl[i].e_exc);
      @(negedge clk);
    end

    // async reset arriving mid-stall with a pending redirect discards both
    stall = 1'b1; npc_sel = 2'd3; jr_target = 32'h5000;
    #2 reset = 1'b0;
    #1 chk_all("async_rst", 32'h3000, 32'h3000, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_hold", 32'h3000, 32'h3000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; npc_sel = 2'd0;
    @(posedge clk); #1;
    chk_all("rst_e1", 32'h3004, 32'h3000, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_e2", 32'h3008, 32'h3004, 32'h1, 1'b1, 1'b0);

    m_fpc = 32'h3008; m_dpc = 32'h3004; m_di = 32'h1; m_v = 1'b1; m_exc = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      stall     = ($urandom_range(0, 3) == 0);
      npc_sel   = 2'($urandom_range(0, 3));
      br_target = 32'h3000 + 32'($urandom_range(0, 32'h4400));
      jr_target = 32'h3000 + 32'($urandom_range(0, 32'h4400));
      if ($urandom_range(0, 7) != 0) begin
        br_target[1:0] = 2'b00;
        jr_target[1:0] = 2'b00;
      end
      j_index = 26'h0000C00 + 26'($urandom_range(0, 32'h1100));
      case (npc_sel)
        2'd0:    n_fpc = m_fpc + 32'd4;
        2'd1:    n_fpc = br_target;
        2'd2:    n_fpc = {m_dpc[31:28], j_index, 2'b00};
        default: n_fpc = jr_target;
      endcase
      if (!stall) begin
        m_exc = exc_of(m_fpc);
        m_di  = m_exc ? 32'h0 : im_word(m_fpc);
        m_dpc = m_fpc;
        m_v   = 1'b1;
        m_fpc = n_fpc;
      end
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", k), m_fpc, m_dpc, m_di, m_v, m_exc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
